// File: rtl/fetch_unit.sv
// Instruction prefetcher: DEPTH-entry queue fed by a fixed one-cycle-latency imem, with redirect and halt.
// Defining FETCH_PERF_EN adds a saturating 32-bit head-transfer counter on perf_cnt.
module fetch_unit #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic [DWIDTH-1:0] imem_data,
    input  logic              redir,
    input  logic [AWIDTH-1:0] redir_pc,
    input  logic              halt_in,
    output logic [DWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [AWIDTH-1:0] pc,
    output logic              hlt
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic              infl_q, infl_d;
    logic [AWIDTH-1:0] infl_addr_q, infl_addr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] last_instr_q;
    logic [AWIDTH-1:0] last_pc_q;

    logic [DWIDTH-1:0] data_mem [DEPTH];
    logic [AWIDTH-1:0] addr_mem [DEPTH];

    logic head_vld;
    logic enq;
    logic deq;
    logic can_issue;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        infl_d      = 1'b0;
        infl_addr_d = infl_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;

        head_vld  = (cnt_q != '0);
        deq       = head_vld & instr_ready;
        // A redirect kills the response of the request issued last cycle.
        enq       = infl_q & ~redir;
        // Credit check counts the outstanding response so the queue can never overflow.
        can_issue = (state_q == RUN) & ~redir & ((cnt_q + CW'(infl_q)) < DEPTH_C);
        imem_req  = rst & can_issue;
        imem_addr = pc_q;

        if (redir) begin
            state_d  = RUN;
            pc_d     = redir_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (imem_req) begin
                infl_d      = 1'b1;
                infl_addr_d = pc_q;
                pc_d        = pc_q + AWIDTH'(2);
            end
            if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + CW'(enq) - CW'(deq);
            if (state_q == RUN && halt_in) state_d = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            pc_q         <= '0;
            infl_q       <= 1'b0;
            infl_addr_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            // Shadow of the head so instr/instr_pc hold once the queue runs dry.
            if (head_vld) begin
                last_instr_q <= data_mem[rd_ptr_q];
                last_pc_q    <= addr_mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            data_mem[wr_ptr_q] <= imem_data;
            addr_mem[wr_ptr_q] <= infl_addr_q;
        end
    end

    assign instr_valid = head_vld;
    assign instr       = head_vld ? data_mem[rd_ptr_q] : last_instr_q;
    assign instr_pc    = head_vld ? addr_mem[rd_ptr_q] : last_pc_q;
    assign pc          = pc_q;
    assign hlt         = (state_q == HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt_q <= '0;
        end else if (deq && perf_cnt_q != 32'hFFFF_FFFF) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
        end
    end

    assign perf_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redir;
    logic [15:0] redir_pc;
    logic        halt_in;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc;
    logic        hlt;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_cnt;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.DWIDTH(16), .AWIDTH(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .redir(redir), .redir_pc(redir_pc), .halt_in(halt_in),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .hlt(hlt)
`ifdef FETCH_PERF_EN
        , .perf_cnt(perf_cnt)
`endif
    );

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] a;
    } ent_t;

    // Reference model state
    ent_t        q_m[$];
    logic [15:0] pc_m, infl_a_m, last_d_m, last_a_m;
    bit          halted_m, infl_m;
    logic [31:0] perf_m;

    // Expected outputs for the current cycle
    bit          e_req, e_vld, e_hlt;
    logic [15:0] e_addr, e_instr, e_ipc, e_pc;

    int ncmp = 0;
    int nerr = 0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic model_reset();
        q_m.delete();
        pc_m = '0; infl_m = 0; infl_a_m = '0; halted_m = 0;
        last_d_m = '0; last_a_m = '0; perf_m = '0;
    endtask

    // Drive one cycle of inputs and compute what the block should show before the edge.
    task automatic prep(input bit r, input logic [15:0] rpc, input bit h, input bit rdy);
        @(negedge clk);
        redir = r; redir_pc = rpc; halt_in = h; instr_ready = rdy;
        imem_data = infl_m ? memf(infl_a_m) : 16'($urandom);
        e_req   = rst && !halted_m && !r && (q_m.size() + int'(infl_m) < DEPTH);
        e_addr  = pc_m;
        e_vld   = q_m.size() > 0;
        e_instr = e_vld ? q_m[0].d : last_d_m;
        e_ipc   = e_vld ? q_m[0].a : last_a_m;
        e_pc    = pc_m;
        e_hlt   = halted_m;
        #1;
    endtask

    task automatic commit();
        ent_t e;
        @(posedge clk);
        if (e_vld) begin last_d_m = q_m[0].d; last_a_m = q_m[0].a; end
        if (e_vld && instr_ready) begin
            void'(q_m.pop_front());
            if (perf_m != 32'hFFFF_FFFF) perf_m++;
        end
        if (redir) begin
            q_m.delete(); infl_m = 0; pc_m = redir_pc; halted_m = 0;
        end else begin
            if (infl_m) begin e.d = memf(infl_a_m); e.a = infl_a_m; q_m.push_back(e); end
            infl_m = e_req; infl_a_m = pc_m;
            if (e_req) pc_m = pc_m + 16'd2;
            if (halt_in) halted_m = 1;
        end
    endtask

    task automatic test_reset();
        ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL reset_req: got %b want 0", imem_req); end
        ncmp++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL reset_vld: got %b want 0", instr_valid); end
        ncmp++; if (instr !== 16'h0 || instr_pc !== 16'h0) begin nerr++; $display("FAIL reset_instr: got %h@%h want 0000@0000", instr, instr_pc); end
        ncmp++; if (pc !== 16'h0 || hlt !== 1'b0) begin nerr++; $display("FAIL reset_pc: got pc=%h hlt=%b want 0000/0", pc, hlt); end
`ifdef FETCH_PERF_EN
        ncmp++; if (perf_cnt !== 32'h0) begin nerr++; $display("FAIL reset_perf: got %h want 0", perf_cnt); end
`endif
        @(posedge clk); #2 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 20; k++) begin
            prep(0, 16'h0, 0, 1);
            ncmp++; if (imem_req !== e_req || (e_req && imem_addr !== e_addr)) begin nerr++; $display("FAIL stream_req k=%0d: got %b/%h want %b/%h", k, imem_req, imem_addr, e_req, e_addr); end
            ncmp++; if (instr_valid !== e_vld || instr !== e_instr || instr_pc !== e_ipc) begin nerr++; $display("FAIL stream_head k=%0d: got %b %h@%h want %b %h@%h", k, instr_valid, instr, instr_pc, e_vld, e_instr, e_ipc); end
            ncmp++; if (imem_req !== 1'b1 || imem_addr !== 16'(2 * k)) begin nerr++; $display("FAIL stream_addr k=%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, 16'(2 * k)); end
            if (k < 2) begin
                ncmp++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL stream_lat k=%0d: got vld=%b want 0", k, instr_valid); end
            end else begin
                ncmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'(2 * (k - 2))) begin nerr++; $display("FAIL stream_rate k=%0d: got %b@%h want 1@%h", k, instr_valid, instr_pc, 16'(2 * (k - 2))); end
            end
            commit();
        end
    endtask

    task automatic test_backpressure();
        int          nreq = 0;
        logic [15:0] exp_pc = 16'h0100;
        prep(1, 16'h0100, 0, 0);
        commit();
        for (int k = 0; k < 10; k++) begin
            prep(0, 16'h0, 0, 0);
            ncmp++; if (imem_req !== e_req || (e_req && imem_addr !== e_addr)) begin nerr++; $display("FAIL bp_req k=%0d: got %b/%h want %b/%h", k, imem_req, imem_addr, e_req, e_addr); end
            if (imem_req === 1'b1) nreq++;
            commit();
        end
        ncmp++; if (nreq != 4) begin nerr++; $display("FAIL bp_count: got %0d requests want 4", nreq); end
        ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL bp_stall: got req=%b want 0", imem_req); end
        for (int k = 0; k < 14; k++) begin
            prep(0, 16'h0, 0, 1);
            ncmp++; if (instr_valid !== e_vld || instr !== e_instr || instr_pc !== e_ipc) begin nerr++; $display("FAIL bp_head k=%0d: got %b %h@%h want %b %h@%h", k, instr_valid, instr, instr_pc, e_vld, e_instr, e_ipc); end
            if (instr_valid === 1'b1) begin
                ncmp++; if (instr_pc !== exp_pc) begin nerr++; $display("FAIL bp_order: got %h want %h", instr_pc, exp_pc); end
                exp_pc = exp_pc + 16'd2;
            end
            commit();
        end
    endtask

    task automatic test_redirect();
        prep(1, 16'h0000, 0, 1);
        commit();
        for (int k = 0; k < 4; k++) begin
            prep(0, 16'h0, 0, 1);
            ncmp++; if (imem_req !== 1'b1 || imem_addr !== 16'(2 * k)) begin nerr++; $display("FAIL rd_pre k=%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, 16'(2 * k)); end
            commit();
        end
        prep(1, 16'h0040, 0, 1);
        ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL rd_noreq: got req=%b want 0", imem_req); end
        commit();
        prep(0, 16'h0, 0, 1);
        ncmp++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL rd_flush: got vld=%b want 0", instr_valid); end
        ncmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin nerr++; $display("FAIL rd_target: got %b/%h want 1/0040", imem_req, imem_addr); end
        commit();
        for (int k = 0; k < 8; k++) begin
            prep(0, 16'h0, 0, 1);
            ncmp++; if (instr_valid !== e_vld || instr !== e_instr || instr_pc !== e_ipc) begin nerr++; $display("FAIL rd_head k=%0d: got %b %h@%h want %b %h@%h", k, instr_valid, instr, instr_pc, e_vld, e_instr, e_ipc); end
            ncmp++; if (instr_valid === 1'b1 && instr_pc === 16'h0006) begin nerr++; $display("FAIL rd_killed: got 0006 delivered want never"); end
            commit();
        end
    endtask

    task automatic test_halt();
        logic [15:0] exp_pc = 16'h0008;
        int          ndrain = 0;
        prep(1, 16'h0008, 0, 0);
        commit();
        for (int k = 0; k < 6; k++) begin prep(0, 16'h0, 0, 0); commit(); end
        prep(0, 16'h0, 1, 0);
        ncmp++; if (pc !== 16'h0010) begin nerr++; $display("FAIL halt_pc0: got %h want 0010", pc); end
        commit();
        for (int k = 0; k < 8; k++) begin
            prep(0, 16'h0, 0, 1);
            ncmp++; if (hlt !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0010) begin nerr++; $display("FAIL halt_state k=%0d: got hlt=%b req=%b pc=%h want 1/0/0010", k, hlt, imem_req, pc); end
            ncmp++; if (instr_valid !== e_vld || instr !== e_instr || instr_pc !== e_ipc) begin nerr++; $display("FAIL halt_head k=%0d: got %b %h@%h want %b %h@%h", k, instr_valid, instr, instr_pc, e_vld, e_instr, e_ipc); end
            if (instr_valid === 1'b1) begin
                ncmp++; if (instr_pc !== exp_pc) begin nerr++; $display("FAIL halt_drain: got %h want %h", instr_pc, exp_pc); end
                exp_pc = exp_pc + 16'd2; ndrain++;
            end
            commit();
        end
        ncmp++; if (ndrain != 4) begin nerr++; $display("FAIL halt_ndrain: got %0d want 4", ndrain); end
        prep(1, 16'h0000, 0, 1);
        commit();
        prep(0, 16'h0, 0, 1);
        ncmp++; if (hlt !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin nerr++; $display("FAIL halt_resume: got hlt=%b req=%b addr=%h want 0/1/0000", hlt, imem_req, imem_addr); end
        commit();
    endtask

    task automatic test_wrap_reset();
        logic [15:0] want [3];
        bit          seen = 0;
        want[0] = 16'hFFFC; want[1] = 16'hFFFE; want[2] = 16'h0000;
        prep(1, 16'hFFFC, 0, 1);
        commit();
        for (int k = 0; k < 4; k++) begin
            prep(0, 16'h0, 0, 1);
            if (k < 3) begin
                ncmp++; if (imem_req !== 1'b1 || imem_addr !== want[k]) begin nerr++; $display("FAIL wrap_addr k=%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, want[k]); end
            end
            commit();
        end
        #2 rst = 1'b0;
        #1;
        ncmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || hlt !== 1'b0) begin nerr++; $display("FAIL rst_ctl: got req=%b vld=%b hlt=%b want 0/0/0", imem_req, instr_valid, hlt); end
        ncmp++; if (instr !== 16'h0 || instr_pc !== 16'h0 || pc !== 16'h0) begin nerr++; $display("FAIL rst_data: got %h@%h pc=%h want 0000@0000 pc=0000", instr, instr_pc, pc); end
`ifdef FETCH_PERF_EN
        ncmp++; if (perf_cnt !== 32'h0) begin nerr++; $display("FAIL rst_perf: got %h want 0", perf_cnt); end
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            prep(0, 16'h0, 0, 1);
            if (k == 0) begin
                ncmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin nerr++; $display("FAIL rst_first: got %b/%h want 1/0000", imem_req, imem_addr); end
            end
            if (instr_valid === 1'b1 && !seen) begin
                seen = 1;
                ncmp++; if (instr_pc !== 16'h0000) begin nerr++; $display("FAIL rst_discard: got first pc %h want 0000", instr_pc); end
            end
            ncmp++; if (instr_valid !== e_vld || instr !== e_instr || instr_pc !== e_ipc) begin nerr++; $display("FAIL rst_head k=%0d: got %b %h@%h want %b %h@%h", k, instr_valid, instr, instr_pc, e_vld, e_instr, e_ipc); end
            commit();
        end
    endtask

    task automatic test_random();
        bit          r, h, rdy;
        logic [15:0] rpc;
        for (int k = 0; k < 400; k++) begin
            r   = ($urandom_range(15) == 0);
            h   = ($urandom_range(19) == 0);
            rdy = ($urandom_range(3) != 0);
            rpc = 16'($urandom) & 16'hFFFE;
            prep(r, rpc, h, rdy);
            ncmp++; if (imem_req !== e_req || (e_req && imem_addr !== e_addr)) begin nerr++; $display("FAIL rnd_req k=%0d: got %b/%h want %b/%h", k, imem_req, imem_addr, e_req, e_addr); end
            ncmp++; if (instr_valid !== e_vld || instr !== e_instr || instr_pc !== e_ipc) begin nerr++; $display("FAIL rnd_head k=%0d: got %b %h@%h want %b %h@%h", k, instr_valid, instr, instr_pc, e_vld, e_instr, e_ipc); end
            ncmp++; if (pc !== e_pc || hlt !== e_hlt) begin nerr++; $display("FAIL rnd_pc k=%0d: got pc=%h hlt=%b want pc=%h hlt=%b", k, pc, hlt, e_pc, e_hlt); end
`ifdef FETCH_PERF_EN
            ncmp++; if (perf_cnt !== perf_m) begin nerr++; $display("FAIL rnd_perf k=%0d: got %0d want %0d", k, perf_cnt, perf_m); end
`endif
            commit();
        end
    endtask

    initial begin
        rst = 1'b0; redir = 1'b0; redir_pc = '0; halt_in = 1'b0;
        instr_ready = 1'b0; imem_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
